// File: rtl/oled_seq_pkg.sv
// Shared definitions for the OLED bus sequencer: FSM encoding, error codes,
// and the levels the SPI lines rest at when no source owns the bus.
package oled_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SELECT = 3'd2,
        ST_RUN    = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INIT_TO = 2'b01;
    localparam logic [1:0] ERR_CLI_TO  = 2'b10;
    localparam logic [1:0] ERR_BAD_SEL = 2'b11;

    localparam logic BUS_CS_IDLE   = 1'b1;
    localparam logic BUS_SDIN_IDLE = 1'b0;
    localparam logic BUS_SCLK_IDLE = 1'b1;
    localparam logic BUS_DC_IDLE   = 1'b0;

    // A single client still needs a 1-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oled_seq_watchdog.sv
// Per-phase timeout: counts enabled cycles since the last clear and flags the
// cycle in which the phase has used up its TO_CYC-cycle allowance.
module oled_seq_watchdog #(
    parameter int          TO_W   = 24,
    parameter int unsigned TO_CYC = (1 << 24) - 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam logic [TO_W-1:0] LIM = TO_W'(TO_CYC - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != LIM))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // cnt_q holds the number of phase cycles already completed before this one.
    assign expired_o = en_i && (cnt_q == LIM);

endmodule

// File: rtl/oled_seq_ctrl.sv
// Sequences the OLED SPI bus between the init block and a set of display
// clients: one-time init, then one-shot or looping client passes.
module oled_seq_ctrl
    import oled_seq_pkg::*;
#(
    parameter int          NUM_CLIENTS = 4,
    parameter int          TO_W        = 24,
    parameter int unsigned TO_CYC      = (1 << 24) - 1,
    localparam int         SEL_W       = sel_width(NUM_CLIENTS)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   STOP,
    input  logic                   LOOP,
    input  logic [SEL_W-1:0]       CLIENT_SEL,
    output logic                   INIT_EN,
    input  logic                   INIT_FIN,
    input  logic                   INIT_CS,
    input  logic                   INIT_SDO,
    input  logic                   INIT_SCLK,
    input  logic                   INIT_DC,
    output logic [NUM_CLIENTS-1:0] CLI_EN,
    input  logic [NUM_CLIENTS-1:0] CLI_FIN,
    input  logic [NUM_CLIENTS-1:0] CLI_CS,
    input  logic [NUM_CLIENTS-1:0] CLI_SDO,
    input  logic [NUM_CLIENTS-1:0] CLI_SCLK,
    input  logic [NUM_CLIENTS-1:0] CLI_DC,
    output logic                   CS,
    output logic                   SDIN,
    output logic                   SCLK,
    output logic                   DC,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [1:0]             ERR,
    output logic [SEL_W-1:0]       ACTIVE
);
    // Client vectors are widened to the full select range so an index can
    // never fall outside the vector.
    localparam int NPAD = 1 << SEL_W;

    state_e           state_q, state_d;
    logic             init_ok_q, init_ok_d;
    logic             stop_q, stop_d;
    logic [1:0]       err_q, err_d;
    logic [SEL_W-1:0] act_q, act_d;

    logic [NPAD-1:0]  fin_pad, cs_pad, sdo_pad, sclk_pad, dc_pad, en_pad;
    logic             in_init, in_run, wd_exp, cli_fin, sel_bad, stop_now;

    assign fin_pad  = NPAD'(CLI_FIN);
    assign cs_pad   = NPAD'(CLI_CS);
    assign sdo_pad  = NPAD'(CLI_SDO);
    assign sclk_pad = NPAD'(CLI_SCLK);
    assign dc_pad   = NPAD'(CLI_DC);

    assign in_init  = (state_q == ST_INIT);
    assign in_run   = (state_q == ST_RUN);
    assign cli_fin  = fin_pad[act_q];
    assign sel_bad  = int'(CLIENT_SEL) >= NUM_CLIENTS;
    assign stop_now = stop_q | STOP;

    oled_seq_watchdog #(
        .TO_W   (TO_W),
        .TO_CYC (TO_CYC)
    ) u_wd (
        .CLK       (CLK),
        .RST       (RST),
        .clear_i   (!(in_init || in_run)),
        .en_i      (in_init || in_run),
        .expired_o (wd_exp)
    );

    always_comb begin
        state_d   = state_q;
        init_ok_d = init_ok_q;
        stop_d    = stop_q;
        err_d     = err_q;
        act_d     = act_q;
        if (BUSY) stop_d = stop_now;
        unique case (state_q)
            ST_IDLE: if (START) begin
                state_d = init_ok_q ? ST_SELECT : ST_INIT;
                stop_d  = STOP;
            end
            // FIN is tested before the timeout so a same-cycle finish succeeds.
            ST_INIT: if (INIT_FIN) begin
                init_ok_d = 1'b1;
                state_d   = ST_SELECT;
            end else if (wd_exp) begin
                state_d = ST_FAULT;
                err_d   = ERR_INIT_TO;
            end
            ST_SELECT: begin
                act_d = CLIENT_SEL;
                if (sel_bad) begin
                    state_d = ST_FAULT;
                    err_d   = ERR_BAD_SEL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: if (cli_fin) begin
                state_d = (LOOP && !stop_now) ? ST_GAP : ST_DONE;
            end else if (wd_exp) begin
                state_d = ST_FAULT;
                err_d   = ERR_CLI_TO;
            end
            ST_GAP:  state_d = ST_SELECT;
            ST_DONE: if (START) begin
                state_d = ST_SELECT;
                stop_d  = STOP;
            end
            ST_FAULT: if (START) begin
                state_d   = ST_INIT;
                err_d     = ERR_NONE;
                init_ok_d = 1'b0;
                stop_d    = STOP;
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) stop_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            init_ok_q <= 1'b0;
            stop_q    <= 1'b0;
            err_q     <= ERR_NONE;
            act_q     <= '0;
        end else begin
            state_q   <= state_d;
            init_ok_q <= init_ok_d;
            stop_q    <= stop_d;
            err_q     <= err_d;
            act_q     <= act_d;
        end
    end

    always_comb begin
        en_pad        = '0;
        en_pad[act_q] = in_run;
    end

    assign CLI_EN  = en_pad[NUM_CLIENTS-1:0];
    assign INIT_EN = in_init;
    assign BUSY    = in_init | in_run | (state_q == ST_SELECT) | (state_q == ST_GAP);
    assign DONE    = (state_q == ST_DONE);
    assign ERR     = err_q;
    assign ACTIVE  = act_q;

    always_comb begin
        CS   = BUS_CS_IDLE;
        SDIN = BUS_SDIN_IDLE;
        SCLK = BUS_SCLK_IDLE;
        DC   = BUS_DC_IDLE;
        if (in_init) begin
            CS   = INIT_CS;
            SDIN = INIT_SDO;
            SCLK = INIT_SCLK;
            DC   = INIT_DC;
        end else if (in_run) begin
            CS   = cs_pad[act_q];
            SDIN = sdo_pad[act_q];
            SCLK = sclk_pad[act_q];
            DC   = dc_pad[act_q];
        end
    end

endmodule

// File: tb/tb_oled_seq_ctrl.sv
// Scoreboard bench for oled_seq_ctrl: stimulus queues expected phase events,
// a negedge monitor turns DUT output edges into events and compares them.
`timescale 1ns/1ps
module tb_oled_seq_ctrl;

    localparam int NC = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          START = 1'b0, STOP = 1'b0, LOOP = 1'b0;
    logic [1:0]    SEL = 2'd0;
    logic          INIT_EN;
    logic          INIT_FIN = 1'b0, INIT_CS = 1'b0, INIT_SDO = 1'b0, INIT_SCLK = 1'b0, INIT_DC = 1'b0;
    logic [NC-1:0] CLI_EN;
    logic [NC-1:0] CLI_FIN = '0, CLI_CS = '0, CLI_SDO = '0, CLI_SCLK = '0, CLI_DC = '0;
    logic          CS, SDIN, SCLK, DC, BUSY, DONE;
    logic [1:0]    ERR, ACTIVE;

    oled_seq_ctrl #(.NUM_CLIENTS(NC), .TO_W(24), .TO_CYC(50)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .LOOP(LOOP), .CLIENT_SEL(SEL),
        .INIT_EN(INIT_EN), .INIT_FIN(INIT_FIN), .INIT_CS(INIT_CS), .INIT_SDO(INIT_SDO),
        .INIT_SCLK(INIT_SCLK), .INIT_DC(INIT_DC),
        .CLI_EN(CLI_EN), .CLI_FIN(CLI_FIN), .CLI_CS(CLI_CS), .CLI_SDO(CLI_SDO),
        .CLI_SCLK(CLI_SCLK), .CLI_DC(CLI_DC),
        .CS(CS), .SDIN(SDIN), .SCLK(SCLK), .DC(DC), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .ACTIVE(ACTIVE)
    );

    // Three-client instance, used for the out-of-range select case.
    logic       START3 = 1'b0;
    logic [1:0] SEL3 = 2'd3;
    logic       INIT3_EN, CS3, SDIN3, SCLK3, DC3, BUSY3, DONE3;
    logic [2:0] CLI3_EN;
    logic [1:0] ERR3, ACT3;

    oled_seq_ctrl #(.NUM_CLIENTS(3), .TO_W(24), .TO_CYC(50)) dut3 (
        .CLK(CLK), .RST(RST), .START(START3), .STOP(1'b0), .LOOP(1'b0), .CLIENT_SEL(SEL3),
        .INIT_EN(INIT3_EN), .INIT_FIN(1'b1), .INIT_CS(1'b0), .INIT_SDO(1'b0),
        .INIT_SCLK(1'b0), .INIT_DC(1'b0),
        .CLI_EN(CLI3_EN), .CLI_FIN(3'b111), .CLI_CS(3'b000), .CLI_SDO(3'b000),
        .CLI_SCLK(3'b000), .CLI_DC(3'b000),
        .CS(CS3), .SDIN(SDIN3), .SCLK(SCLK3), .DC(DC3), .BUSY(BUSY3), .DONE(DONE3),
        .ERR(ERR3), .ACTIVE(ACT3)
    );

    int total = 0;
    int bad   = 0;

    typedef enum int {EV_INIT, EV_RUN, EV_REND, EV_DONE, EV_ERR} ev_k;
    typedef struct { ev_k k; int v; } ev_t;
    ev_t exp_q[$];

    task automatic expect_ev(input ev_k k, input int v);
        ev_t e;
        e.k = k;
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input ev_k k, input int v);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got %s=%0d, expected no event", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.k != k || e.v != v) begin
                bad++;
                $display("FAIL sb_event: got %s=%0d, expected %s=%0d", k.name(), v, e.k.name(), e.v);
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reactive sources: FIN after a programmed number of enabled cycles (0 =
    // never), while unselected sources keep their FIN lines high throughout.
    int ic = 0, cc = 0;
    int init_lat = 10, cli_lat = 20;
    initial begin
        forever begin
            @(posedge CLK); #1;
            ic = INIT_EN ? ic + 1 : 0;
            cc = (CLI_EN != '0) ? cc + 1 : 0;
            INIT_FIN = INIT_EN ? (ic == init_lat) : 1'b1;
            CLI_FIN  = ((CLI_EN != '0 && cc == cli_lat) ? CLI_EN : '0) | ~CLI_EN;
            {INIT_CS, INIT_SDO, INIT_SCLK, INIT_DC} = 4'($urandom);
            CLI_CS   = 4'($urandom);
            CLI_SDO  = 4'($urandom);
            CLI_SCLK = 4'($urandom);
            CLI_DC   = 4'($urandom);
        end
    end

    // Event value for EV_RUN: idle-but-busy cycles before the run * 16 + CLI_EN.
    int         init_len = 0, run_len = 0, gap = 0;
    logic       p_init = 1'b0, p_done = 1'b0;
    logic [3:0] p_cli = '0;
    logic [1:0] p_err = '0;
    logic [3:0] eb;
    logic       cli3_seen = 1'b0;

    always @(negedge CLK) begin
        if (CLI3_EN != 3'b000) cli3_seen = 1'b1;
        if (RST) begin
            init_len = 0; run_len = 0; gap = 0;
            p_init = 1'b0; p_done = 1'b0; p_cli = '0; p_err = '0;
        end else begin
            if (INIT_EN) init_len++;
            else if (p_init) begin got_ev(EV_INIT, init_len); init_len = 0; end
            if (CLI_EN != '0) run_len++;
            else if (p_cli != '0) begin got_ev(EV_REND, run_len); run_len = 0; end
            if (CLI_EN != '0 && p_cli == '0) got_ev(EV_RUN, gap * 16 + int'(CLI_EN));
            if (BUSY && !INIT_EN && CLI_EN == '0) gap++; else gap = 0;
            if (DONE && !p_done) got_ev(EV_DONE, int'(ACTIVE));
            if (ERR != p_err) got_ev(EV_ERR, int'(ERR));
            eb = 4'b1010;
            if (INIT_EN) eb = {INIT_CS, INIT_SDO, INIT_SCLK, INIT_DC};
            else for (int i = 0; i < NC; i++)
                if (CLI_EN[i]) eb = {CLI_CS[i], CLI_SDO[i], CLI_SCLK[i], CLI_DC[i]};
            total++;
            if ({CS, SDIN, SCLK, DC} != eb) begin
                bad++;
                $display("FAIL bus_mux: got %b expected %b (INIT_EN=%b CLI_EN=%b)",
                         {CS, SDIN, SCLK, DC}, eb, INIT_EN, CLI_EN);
            end
            p_init = INIT_EN; p_cli = CLI_EN; p_done = DONE; p_err = ERR;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic pulse_start(input logic stp = 1'b0);
        START = 1'b1; STOP = stp;
        tick();
        START = 1'b0; STOP = 1'b0;
    endtask

    function automatic logic cond(input int c);
        case (c)
            0: return DONE;
            1: return CLI_EN != '0;
            2: return CLI_EN == '0;
            3: return ERR != 2'b00;
            4: return ERR3 != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitc(input string nm, input int c, input int budget);
        int n = 0;
        while (!cond(c) && n < budget) begin tick(); n++; end
        if (!cond(c)) begin
            total++; bad++;
            $display("FAIL %s: condition not reached within %0d cycles", nm, budget);
        end
    endtask

    task automatic drain(input string nm);
        tick();
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_busy"}, int'(BUSY), 0);
        chk({pfx, "_done"}, int'(DONE), 0);
        chk({pfx, "_err"}, int'(ERR), 0);
        chk({pfx, "_active"}, int'(ACTIVE), 0);
        chk({pfx, "_init_en"}, int'(INIT_EN), 0);
        chk({pfx, "_cli_en"}, int'(CLI_EN), 0);
        chk({pfx, "_bus"}, int'({CS, SDIN, SCLK, DC}), 4'b1010);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        tick(3);
        chk_idle("reset");
        RST = 1'b0;
        tick();

        // Out-of-range select on the three-client instance.
        START3 = 1'b1; tick(); START3 = 1'b0;
        waitc("badsel_wait", 4, 10);
        chk("badsel_err", int'(ERR3), 3);
        chk("badsel_active", int'(ACT3), 3);
        chk("badsel_busy", int'(BUSY3), 0);
        chk("badsel_init_en", int'(INIT3_EN), 0);

        // First pass: init then client 2, one-shot.
        init_lat = 10; cli_lat = 20; LOOP = 1'b0; SEL = 2'd2;
        expect_ev(EV_INIT, 10);
        expect_ev(EV_RUN, 16 + 4'b0100);
        expect_ev(EV_REND, 20);
        expect_ev(EV_DONE, 2);
        pulse_start();
        waitc("t1_done", 0, 100);
        drain("t1_drain");

        // From DONE: no re-init.
        SEL = 2'd1;
        expect_ev(EV_RUN, 16 + 4'b0010);
        expect_ev(EV_REND, 20);
        expect_ev(EV_DONE, 1);
        pulse_start();
        waitc("t2_done", 0, 100);
        drain("t2_drain");

        // Loop 0,3,0 with STOP in the third pass; a START while busy is ignored.
        cli_lat = 8; LOOP = 1'b1; SEL = 2'd0;
        expect_ev(EV_RUN, 16 + 4'b0001);
        expect_ev(EV_REND, 8);
        expect_ev(EV_RUN, 32 + 4'b1000);
        expect_ev(EV_REND, 8);
        expect_ev(EV_RUN, 32 + 4'b0001);
        expect_ev(EV_REND, 8);
        expect_ev(EV_DONE, 0);
        pulse_start();
        waitc("t3_run1", 1, 20);
        SEL = 2'd3;
        tick(2);
        pulse_start();
        waitc("t3_gap1", 2, 20);
        waitc("t3_run2", 1, 20);
        SEL = 2'd0;
        waitc("t3_gap2", 2, 20);
        waitc("t3_run3", 1, 20);
        tick(2);
        STOP = 1'b1; tick(); STOP = 1'b0;
        waitc("t3_done", 0, 40);
        LOOP = 1'b0;
        drain("t3_drain");

        // Reset in the middle of a run.
        SEL = 2'd1; cli_lat = 0;
        expect_ev(EV_RUN, 16 + 4'b0010);
        pulse_start();
        waitc("t4_run", 1, 20);
        tick(3);
        RST = 1'b1;
        tick();
        chk_idle("midrun_rst");
        RST = 1'b0;
        drain("t4_drain");

        // START+STOP together from IDLE with LOOP=1: single pass; FIN lands
        // on the last allowed cycle of both INIT and RUN.
        init_lat = 50; cli_lat = 50; LOOP = 1'b1; SEL = 2'd3;
        expect_ev(EV_INIT, 50);
        expect_ev(EV_RUN, 16 + 4'b1000);
        expect_ev(EV_REND, 50);
        expect_ev(EV_DONE, 3);
        pulse_start(1'b1);
        waitc("t5_done", 0, 200);
        LOOP = 1'b0;
        drain("t5_drain");

        // Client never finishes.
        SEL = 2'd0; cli_lat = 0;
        expect_ev(EV_RUN, 16 + 4'b0001);
        expect_ev(EV_REND, 50);
        expect_ev(EV_ERR, 2);
        pulse_start();
        waitc("t6_err", 3, 100);
        tick();
        chk("t6_err", int'(ERR), 2);
        chk("t6_cli_en", int'(CLI_EN), 0);
        chk("t6_busy", int'(BUSY), 0);
        drain("t6_drain");

        // From FAULT: re-init, which never finishes.
        init_lat = 0;
        expect_ev(EV_ERR, 0);
        expect_ev(EV_INIT, 50);
        expect_ev(EV_ERR, 1);
        pulse_start();
        waitc("t7_err", 3, 100);
        tick();
        chk("t7_err", int'(ERR), 1);
        chk("t7_init_en", int'(INIT_EN), 0);
        chk("t7_busy", int'(BUSY), 0);
        drain("t7_drain");

        // Recovery from the init fault.
        init_lat = 10; cli_lat = 5; SEL = 2'd2;
        expect_ev(EV_ERR, 0);
        expect_ev(EV_INIT, 10);
        expect_ev(EV_RUN, 16 + 4'b0100);
        expect_ev(EV_REND, 5);
        expect_ev(EV_DONE, 2);
        pulse_start();
        waitc("t8_done", 0, 100);
        chk("t8_err", int'(ERR), 0);
        drain("t8_drain");

        chk("badsel_no_cli_en", int'(cli3_seen), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
